// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control sequencer for the phase-1 DataPath: walks T0..T6 for
// three-register ALU, MUL/DIV, NOP and HALT instructions and counts retirements.
module alu_instr_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      IR_VALUE,
  output logic             PCout,
  output logic             IncPC,
  output logic             MARin,
  output logic             Zin,
  output logic             Zlo_out,
  output logic             Zhi_out,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [15:0]      Rin,
  output logic [15:0]      Rout,
  output logic [4:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state, next;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_hilo, is_nop, is_halt, is_illegal;
  logic       retire;
  logic       unused_ir;

  assign op        = IR_VALUE[31:27];
  assign ra        = IR_VALUE[26:23];
  assign rb        = IR_VALUE[22:19];
  assign rc        = IR_VALUE[18:15];
  assign unused_ir = ^IR_VALUE[14:0];

  assign is_alu     = (op >= 5'd3) && (op <= 5'd10);
  assign is_hilo    = (op == 5'd15) || (op == 5'd16);
  assign is_nop     = (op == 5'd26);
  assign is_halt    = (op == 5'd27);
  assign is_illegal = !(is_alu || is_hilo || is_nop || is_halt);

  // Last execute step of every counted instruction; halt and illegal are not counted.
  assign retire = ((state == S_T3) && is_nop) ||
                  ((state == S_T5) && is_alu) ||
                  (state == S_T6);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= S_IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE: if (run) next = S_T0;
      S_T0:   next = S_T1;
      S_T1:   if (mem_ready) next = S_T2;
      S_T2:   next = S_T3;
      S_T3: begin
        if (is_halt)                next = S_HALT;
        else if (is_alu || is_hilo) next = S_T4;
        else                        next = run ? S_T0 : S_IDLE;
      end
      S_T4:   next = S_T5;
      S_T5:   next = is_hilo ? S_T6 : (run ? S_T0 : S_IDLE);
      S_T6:   next = run ? S_T0 : S_IDLE;
      S_HALT: next = S_HALT;
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    PCout   = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    Zlo_out = 1'b0;
    Zhi_out = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    HIin    = 1'b0;
    LOin    = 1'b0;
    Rin     = 16'h0000;
    Rout    = 16'h0000;
    alu_op  = 5'd0;
    busy    = (state != S_IDLE) && (state != S_HALT);
    halted  = (state == S_HALT);
    case (state)
      S_T0: begin
        PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
      end
      // Held unchanged through memory stalls; Z keeps PC+1 since Zin is low.
      S_T1: begin
        Zlo_out = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: if (is_alu || is_hilo) begin
        Rout = 16'b1 << rb; Yin = 1'b1;
      end
      S_T4: begin
        Rout = 16'b1 << rc; Zin = 1'b1; alu_op = op;
      end
      S_T5: begin
        Zlo_out = 1'b1;
        if (is_hilo) LOin = 1'b1;
        else         Rin  = 16'b1 << ra;
      end
      S_T6: begin
        Zhi_out = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      retired    <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      illegal_op <= (state == S_T3) && is_illegal;
    end
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench: per-instruction expected control traces are built from
// the instruction-class rules and compared cycle by cycle against the sequencer.
module tb_alu_instr_sequencer;

  localparam int CNT_W = 16;

  logic clock, clear_n, run, mem_ready;
  logic [31:0] IR_VALUE;
  logic PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0] alu_op;
  logic busy, halted, illegal_op;
  logic [CNT_W-1:0] retired;

  alu_instr_sequencer #(.CNT_W(CNT_W)) dut (
    .clock(clock), .clear_n(clear_n), .run(run), .mem_ready(mem_ready), .IR_VALUE(IR_VALUE),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy),
    .halted(halted), .illegal_op(illegal_op), .retired(retired)
  );

  typedef struct packed {
    logic pcout, incpc, marin, zin, zlo, zhi, pcin, read, mdrin, mdrout, irin, yin, hiin, loin;
    logic [15:0] rin, rout;
    logic [4:0]  alu_op;
    logic busy, halted, ill;
  } ctl_t;

  ctl_t obs;
  assign obs = {PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read, MDRin, MDRout, IRin,
                Yin, HIin, LOin, Rin, Rout, alu_op, busy, halted, illegal_op};

  ctl_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_ret;
  logic pend_ill;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit cls_alu(input logic [4:0] op);  return op >= 5'd3 && op <= 5'd10; endfunction
  function automatic bit cls_hilo(input logic [4:0] op); return op == 5'd15 || op == 5'd16; endfunction
  function automatic bit legal(input logic [4:0] op);
    return cls_alu(op) || cls_hilo(op) || op == 5'd26 || op == 5'd27;
  endfunction

  // Expected control vector for each cycle of one instruction, starting in T0.
  function automatic void build(input logic [31:0] ir, input int stalls, input logic ill0);
    logic [4:0] op;
    ctl_t c;
    op = ir[31:27];
    exp_q.delete();
    c = '0; c.busy = 1; c.pcout = 1; c.incpc = 1; c.marin = 1; c.zin = 1; c.ill = ill0;
    exp_q.push_back(c);
    for (int s = 0; s <= stalls; s++) begin
      c = '0; c.busy = 1; c.zlo = 1; c.pcin = 1; c.read = 1; c.mdrin = 1;
      exp_q.push_back(c);
    end
    c = '0; c.busy = 1; c.mdrout = 1; c.irin = 1;
    exp_q.push_back(c);
    c = '0; c.busy = 1;
    if (cls_alu(op) || cls_hilo(op)) begin
      c.rout = 16'd1 << ir[22:19]; c.yin = 1;
      exp_q.push_back(c);
      c = '0; c.busy = 1; c.rout = 16'd1 << ir[18:15]; c.zin = 1; c.alu_op = op;
      exp_q.push_back(c);
      c = '0; c.busy = 1; c.zlo = 1;
      if (cls_alu(op)) c.rin = 16'd1 << ir[26:23];
      else c.loin = 1;
      exp_q.push_back(c);
      if (cls_hilo(op)) begin
        c = '0; c.busy = 1; c.zhi = 1; c.hiin = 1;
        exp_q.push_back(c);
      end
    end else begin
      exp_q.push_back(c);
    end
  endfunction

  // Entered at a falling edge with the sequencer in T0; run is released from index drop_k on.
  task automatic exec(input logic [31:0] ir, input int stalls, input int drop_k);
    ctl_t e;
    logic [4:0] op;
    op = ir[31:27];
    IR_VALUE = ir;
    build(ir, stalls, pend_ill);
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      n_checks++;
      if (obs !== e || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL exec ir=%h cyc%0d: got ctl=%h ret=%0d want ctl=%h ret=%0d",
                 ir, k, obs, retired, e, exp_ret);
      end
      mem_ready = !(k >= 1 && k <= stalls);
      run = (k < drop_k);
      @(negedge clock);
    end
    pend_ill = !legal(op);
    if (cls_alu(op) || cls_hilo(op) || op == 5'd26) exp_ret = exp_ret + 1'b1;
  endtask

  task automatic idle_cycles(input int n, input bit go);
    ctl_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.ill = pend_ill;
      pend_ill = 1'b0;
      n_checks++;
      if (obs !== e || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL idle cyc%0d: got ctl=%h ret=%0d want ctl=%h ret=%0d", i, obs, retired, e, exp_ret);
      end
      mem_ready = 1'($urandom);
      run = go && (i == n - 1);
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    clear_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
    exp_ret = '0; pend_ill = 1'b0;
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    IR_VALUE = 32'h0;
    do_reset();
    n_checks++;
    if (obs !== '0 || retired !== '0) begin
      n_fail++;
      $display("FAIL reset: got ctl=%h ret=%0d want 0", obs, retired);
    end
    idle_cycles(4, 1'b1);
  endtask

  task automatic test_alu();
    exec(32'h28918000, 0, 1000);
    n_checks++;
    if (retired !== 16'd1) begin
      n_fail++;
      $display("FAIL alu_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_stall();
    exec(32'h28918000, 3, 1000);
  endtask

  task automatic test_hilo();
    exec(32'h78918000, 0, 1000);
    exec(32'h80000000 | 32'h05A8000, 2, 1000);
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    int cat;
    bit drop;
    for (int i = 0; i < 40; i++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0: op = 5'($urandom_range(3, 10));
        1: op = ($urandom_range(0, 1) == 0) ? 5'd15 : 5'd16;
        2: op = 5'd26;
        default: begin
          op = 5'($urandom_range(0, 31));
          while (legal(op)) op = 5'($urandom_range(0, 31));
        end
      endcase
      drop = ($urandom_range(0, 4) == 0);
      exec({op, 12'($urandom), 15'($urandom)}, $urandom_range(0, 3),
           drop ? $urandom_range(0, 6) : 1000);
      if (drop) idle_cycles($urandom_range(1, 3), 1'b1);
    end
  endtask

  task automatic test_run_drop();
    exec(32'h30918000, 0, 4);
    idle_cycles(5, 1'b1);
  endtask

  task automatic test_illegal_halt();
    ctl_t e;
    logic [CNT_W-1:0] r0;
    r0 = exp_ret;
    exec(32'hF8000000, 0, 1000);
    n_checks++;
    if (exp_ret !== r0 || pend_ill !== 1'b1 || retired !== r0) begin
      n_fail++;
      $display("FAIL illegal_count: got ret=%0d want %0d", retired, r0);
    end
    exec(32'hD8000000, 1, 1000);
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (obs !== e || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL halt cyc%0d: got ctl=%h ret=%0d want ctl=%h ret=%0d", i, obs, retired, e, exp_ret);
      end
      run = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clock);
    end
  endtask

  task automatic test_clear_mid_stall();
    do_reset();
    idle_cycles(2, 1'b1);
    exec(32'h40918000, 1, 1000);
    mem_ready = 1'b0; run = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (Read !== 1'b1 || retired !== 16'd1) begin
      n_fail++;
      $display("FAIL pre_clear: got read=%b ret=%0d want read=1 ret=1", Read, retired);
    end
    #2 clear_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0 || retired !== '0) begin
      n_fail++;
      $display("FAIL async_clear: got ctl=%h ret=%0d want 0", obs, retired);
    end
    @(negedge clock);
    clear_n = 1'b1; run = 1'b0;
    exp_ret = '0; pend_ill = 1'b0;
    idle_cycles(3, 1'b1);
    exec(32'h48918000, 0, 0);
    idle_cycles(2, 1'b0);
  endtask

  initial begin
    clear_n = 1'b1; run = 1'b0; mem_ready = 1'b0; IR_VALUE = '0;
    exp_ret = '0; pend_ill = 1'b0;
    @(negedge clock);
    test_reset();
    test_alu();
    test_stall();
    test_hilo();
    test_back_to_back();
    test_run_drop();
    test_illegal_halt();
    test_clear_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Control unit that sequences the phase-1 DataPath through fetch (T0–T2) and execute (T3–T6) for three-register ALU, MUL/DIV, NOP and HALT instructions. It drives every enable and tri-state select that a testbench FSM currently hand-drives. It decodes the IR, waits on a memory-ready handshake during fetch, and counts retired instructions. It sits beside DataPath, consuming IR_VALUE and driving its control inputs directly.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps)

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = fetch next instruction after current one retires
mem_ready  in  1  memory data valid on MDR_Mem_lines this cycle
IR_VALUE  in  32  current IR contents from DataPath
PCout, IncPC, MARin, Zin  out  1 each  fetch T0 controls
Zlo_out, Zhi_out, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes
Rin  out  16  one-hot GP register load enables (R0in..R15in)
Rout  out  16  one-hot GP register bus-drive selects (R0out..R15out)
alu_op  out  5  ALU opcode to DataPath
busy  out  1  1 in any state except IDLE/HALT
halted  out  1  1 in HALT
illegal_op  out  1  one-cycle pulse on undefined opcode
retired  out  CNT_W  completed-instruction count

Behaviour:
- IR format: [31:27] op, [26:23] ra (dest), [22:19] rb, [18:15] rc. IR is only written in T2, so fields are stable T3–T6.
- Opcodes:
  - 00011–01010: add, sub, and, or, shr, shl, ror, rol (ALU class).
  - 01111: mul; 10000: div (HILO class).
  - 11010: nop; 11011: halt.
  - All others illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. State is registered; all strobe outputs are Moore-decoded from state plus IR fields, with no combinational path from run/mem_ready to strobes. Every output not listed for a state is 0.
- IDLE: go to T0 when run=1.
- T0: PCout, IncPC, MARin, Zin. Go to T1.
- T1: Zlo_out, PCin, Read, MDRin. Stay in T1 while mem_ready=0, with these held; Z is unchanged because Zin=0. Go to T2 on the edge where mem_ready=1.
- T2: MDRout, IRin. Go to T3.
- T3 decode:
  - halt → HALT.
  - nop → retire.
  - illegal → illegal_op=1 on the next cycle for exactly one cycle; count not incremented; next is T0 if run else IDLE.
  - ALU/HILO → Rout[rb], Yin; go to T4.
- T4: Rout[rc], Zin, alu_op=op (held through T4 only; 0 elsewhere). Go to T5.
- T5:
  - ALU: Zlo_out, Rin[ra]; retire.
  - HILO: Zlo_out, LOin; go to T6.
- T6: Zhi_out, HIin; retire.
- Retire: retired += 1 (wraps modulo 2^CNT_W). Next state is T0 if run=1 sampled that cycle, else IDLE. Dropping run mid-instruction never aborts the instruction.
- ra=0 is legal and writes R0.
- Rin and Rout are always one-hot or zero, never both nonzero for the same register.
- HALT: halted=1, all strobes 0. Exit only via clear_n.
- Latency: ALU instruction = 6 cycles + stall cycles; HILO = 7; nop/illegal = 4.
- Reset (clear_n=0, asynchronous, mid-operation included):
  - state=IDLE.
  - All strobes, Rin, Rout, alu_op = 0.
  - busy=0, halted=0, illegal_op=0, retired=0.
  - On release, first transition out of IDLE is on the first rising edge with run=1.

Test Plan:
1. Reset, run=1, mem_ready=1, IR_VALUE=0x28918000 (and R1,R2,R3) → T0..T5 in 6 cycles; T3 Rout=0x0004 with Yin; T4 Rout=0x0008, alu_op=00101, Zin; T5 Rin=0x0002 with Zlo_out; retired=1.
2. Same instruction with mem_ready low 3 cycles in T1 → Read/MDRin/PCin held 4 cycles; T2 follows mem_ready=1 edge; total 9 cycles.
3. IR=0x78918000 (mul; rb=2, rc=3) → T5 asserts LOin+Zlo_out, T6 asserts HIin+Zhi_out; Rin stays 0 throughout; retired=1 after 7 cycles.
4. IR=0xF8000000 (op 11111) → illegal_op pulses one cycle after T3; retired unchanged; refetch T0. Then IR=0xD8000000 (halt) → halted=1, busy=0, all strobes 0 for 20 cycles.
5. run dropped during T4 of OR (0x30918000) → T5 completes with Rin=0x0002, then IDLE; no T0 until run=1.
6. clear_n pulsed low during T1 stall → all outputs 0 immediately, asynchronously; retired=0; restart from IDLE.
